// File: rtl/cnn_pkg.sv
// cnn_pkg: shared state encoding and size/offset/compare helpers for the pooling stage
package cnn_pkg;
  typedef enum logic {IDLE, SCAN} state_t;
  localparam int MAX_PW = 32;
  function automatic int bit_off(input int row, input int col, input int width, input int pw);
    return (row * width + col) * pw;
  endfunction
  function automatic logic signed [MAX_PW-1:0] smax(input logic signed [MAX_PW-1:0] a, input logic signed [MAX_PW-1:0] b);
    return a > b ? a : b;
  endfunction
  function automatic int out_dim(input int in_dim, input int pool);
    return in_dim / pool;
  endfunction
  function automatic int n_win(input int iw, input int ih, input int pool);
    return (iw / pool) * (ih / pool);
  endfunction
endpackage

// File: rtl/pool_addr_gen.sv
// pool_addr_gen: nested window/offset counters for the pooling scan
module pool_addr_gen
  import cnn_pkg::*;
#(
  parameter int IN_WIDTH  = 4,
  parameter int IN_HEIGHT = 4,
  parameter int POOL_SIZE = 2,
  parameter int CW        = 3
) (
  input  logic          clock_i,
  input  logic          reset_ni,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] win_row_o,
  output logic [CW-1:0] win_col_o,
  output logic [CW-1:0] k_row_o,
  output logic [CW-1:0] k_col_o,
  output logic          last_in_window_o,
  output logic          last_window_o
);
  localparam logic [CW-1:0] KMAX = CW'(POOL_SIZE - 1);
  localparam logic [CW-1:0] WCMAX = CW'(out_dim(IN_WIDTH, POOL_SIZE) - 1);
  localparam logic [CW-1:0] WRMAX = CW'(out_dim(IN_HEIGHT, POOL_SIZE) - 1);
  logic [CW-1:0] wr_q, wc_q, kr_q, kc_q, wr_d, wc_d, kr_d, kc_d;
  logic kc_last, kr_last, wc_last, wr_last;
  assign kc_last = kc_q == KMAX;
  assign kr_last = kr_q == KMAX;
  assign wc_last = wc_q == WCMAX;
  assign wr_last = wr_q == WRMAX;
  assign last_in_window_o = kc_last && kr_last;
  assign last_window_o = last_in_window_o && wc_last && wr_last;
  assign win_row_o = wr_q;
  assign win_col_o = wc_q;
  assign k_row_o = kr_q;
  assign k_col_o = kc_q;
  // k_col innermost, then k_row, win_col, win_row; each wraps when the inner one wraps
  always_comb begin
    kc_d = clr_i ? '0 : en_i ? (kc_last ? '0 : kc_q + CW'(1)) : kc_q;
    kr_d = clr_i ? '0 : (en_i && kc_last) ? (kr_last ? '0 : kr_q + CW'(1)) : kr_q;
    wc_d = clr_i ? '0 : (en_i && last_in_window_o) ? (wc_last ? '0 : wc_q + CW'(1)) : wc_q;
    wr_d = clr_i ? '0 : (en_i && last_in_window_o && wc_last) ? (wr_last ? '0 : wr_q + CW'(1)) : wr_q;
  end
  // counter registers
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      wr_q <= '0;
      wc_q <= '0;
      kr_q <= '0;
      kc_q <= '0;
    end else begin
      wr_q <= wr_d;
      wc_q <= wc_d;
      kr_q <= kr_d;
      kc_q <= kc_d;
    end
  end
endmodule

// File: rtl/maxpool_block.sv
// maxpool_block: sequential-scan max pooling with optional ReLU over a latched feature map
module maxpool_block
  import cnn_pkg::*;
#(
  parameter int IN_WIDTH    = 4,
  parameter int IN_HEIGHT   = 4,
  parameter int POOL_SIZE   = 2,
  parameter int POINT_WIDTH = 8,
  parameter bit RELU_EN     = 1'b0,
  localparam int NI = IN_WIDTH * IN_HEIGHT,
  localparam int NW = n_win(IN_WIDTH, IN_HEIGHT, POOL_SIZE)
) (
  input  logic                      clock_i,
  input  logic                      reset_ni,
  input  logic                      start_i,
  input  logic [0:POINT_WIDTH*NI-1] data_in_i,
  output logic [0:POINT_WIDTH*NW-1] data_out_o,
  output logic                      pool_done_o,
  output logic                      busy_o
);
  localparam int OW = out_dim(IN_WIDTH, POOL_SIZE);
  localparam int CW = $clog2((IN_WIDTH > IN_HEIGHT ? IN_WIDTH : IN_HEIGHT) + 1);
  if (POOL_SIZE < 1 || POOL_SIZE > IN_WIDTH || POOL_SIZE > IN_HEIGHT) begin : g_bad_size
    $error("maxpool_block: pool size must be in 1..min(in_width, in_height)");
  end
  state_t state_q, state_d;
  logic [0:POINT_WIDTH*NI-1] in_buf_q, in_buf_d;
  logic [0:POINT_WIDTH*NW-1] out_buf_q, out_buf_d, data_out_q, data_out_d;
  logic [POINT_WIDTH-1:0] run_q, run_d, elem, cur, res;
  logic signed [MAX_PW-1:0] mx;
  logic done_q, done_d, clr, en, last_in_window, last_window;
  logic [CW-1:0] wr, wc, kr, kc;
  int idx, slot;
  pool_addr_gen #(
    .IN_WIDTH (IN_WIDTH),
    .IN_HEIGHT(IN_HEIGHT),
    .POOL_SIZE(POOL_SIZE),
    .CW       (CW)
  ) u_addr (
    .clock_i         (clock_i),
    .reset_ni        (reset_ni),
    .clr_i           (clr),
    .en_i            (en),
    .win_row_o       (wr),
    .win_col_o       (wc),
    .k_row_o         (kr),
    .k_col_o         (kc),
    .last_in_window_o(last_in_window),
    .last_window_o   (last_window)
  );
  assign data_out_o = data_out_q;
  assign pool_done_o = done_q;
  assign busy_o = state_q == SCAN;
  // element fetch, running max, ReLU, and FSM next state
  always_comb begin
    state_d = state_q;
    in_buf_d = in_buf_q;
    out_buf_d = out_buf_q;
    data_out_d = data_out_q;
    run_d = run_q;
    done_d = 1'b0;
    clr = 1'b0;
    en = 1'b0;
    idx = bit_off(int'(wr) * POOL_SIZE + int'(kr), int'(wc) * POOL_SIZE + int'(kc), IN_WIDTH, POINT_WIDTH);
    slot = bit_off(int'(wr), int'(wc), OW, POINT_WIDTH);
    elem = in_buf_q[idx+:POINT_WIDTH];
    mx = smax(MAX_PW'(signed'(run_q)), MAX_PW'(signed'(elem)));
    cur = (kr == '0 && kc == '0) ? elem : mx[POINT_WIDTH-1:0];
    res = (RELU_EN && cur[POINT_WIDTH-1]) ? '0 : cur;
    if (state_q == IDLE) begin
      if (start_i) begin
        in_buf_d = data_in_i;
        clr = 1'b1;
        state_d = SCAN;
      end
    end else begin
      en = 1'b1;
      run_d = cur;
      if (last_in_window) out_buf_d[slot+:POINT_WIDTH] = res;
      if (last_window) begin
        data_out_d = out_buf_d;
        done_d = 1'b1;
        state_d = IDLE;
      end
    end
  end
  // state and datapath registers; reset discards any partial pass
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      in_buf_q <= '0;
      out_buf_q <= '0;
      data_out_q <= '0;
      run_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      in_buf_q <= in_buf_d;
      out_buf_q <= out_buf_d;
      data_out_q <= data_out_d;
      run_q <= run_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_maxpool_block.sv
// tb_maxpool_block: scoreboard bench for default, ReLU and 5x5 pooling instances
module tb_maxpool_block;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0, start = 1'b0;
  logic [0:127] d4;
  logic [0:199] d5;
  logic [0:31] dout0, dout1, dout2;
  logic done0, done1, done2, busy0, busy1, busy2;
  int checks = 0, failures = 0, cyc = 0;
  typedef struct {logic [0:31] d; int c;} exp_t;
  exp_t q0[$], q1[$], q2[$];
  exp_t e0, e1, e2;
  localparam logic [0:31] RAMP = 32'h05070d0f, REV = 32'h0f0d0705, U2 = 32'h0507090a;

  always @(posedge clk) cyc <= cyc + 1;

  maxpool_block u0 (.clock_i(clk), .reset_ni(rst_n), .start_i(start), .data_in_i(d4),
    .data_out_o(dout0), .pool_done_o(done0), .busy_o(busy0));
  maxpool_block #(.RELU_EN(1'b1)) u1 (.clock_i(clk), .reset_ni(rst_n), .start_i(start), .data_in_i(d4),
    .data_out_o(dout1), .pool_done_o(done1), .busy_o(busy1));
  maxpool_block #(.IN_WIDTH(5), .IN_HEIGHT(5)) u2 (.clock_i(clk), .reset_ni(rst_n), .start_i(start), .data_in_i(d5),
    .data_out_o(dout2), .pool_done_o(done2), .busy_o(busy2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic go(input logic [0:31] x0, input logic [0:31] x1);
    start = 1'b1;
    tick;
    start = 1'b0;
    q0.push_back('{x0, cyc + 16});
    q1.push_back('{x1, cyc + 16});
    q2.push_back('{U2, cyc + 16});
  endtask

  task automatic drain;
    for (int i = 0; i < 40 && (q0.size() + q1.size() + q2.size()) != 0; i++) tick;
    chk("drain_pending", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
  endtask

  task automatic set_ramp;
    for (int i = 0; i < 16; i++) d4[i*8+:8] = 8'(i);
  endtask

  always @(negedge clk) if (done0) begin
    checks++;
    assert (q0.size() != 0) else begin failures++; $error("FAIL u0_spurious_done got=1 exp=0"); end
    if (q0.size() != 0) begin
      e0 = q0.pop_front();
      chk("u0_data", dout0, e0.d);
      chk("u0_latency", 32'(cyc), 32'(e0.c));
    end
  end

  always @(negedge clk) if (done1) begin
    checks++;
    assert (q1.size() != 0) else begin failures++; $error("FAIL u1_spurious_done got=1 exp=0"); end
    if (q1.size() != 0) begin
      e1 = q1.pop_front();
      chk("u1_relu_data", dout1, e1.d);
      chk("u1_latency", 32'(cyc), 32'(e1.c));
    end
  end

  always @(negedge clk) if (done2) begin
    checks++;
    assert (q2.size() != 0) else begin failures++; $error("FAIL u2_spurious_done got=1 exp=0"); end
    if (q2.size() != 0) begin
      e2 = q2.pop_front();
      chk("u2_5x5_data", dout2, e2.d);
      chk("u2_latency", 32'(cyc), 32'(e2.c));
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    set_ramp;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        d5[(r*5+c)*8+:8] = (r == 4 || c == 4) ? 8'd127 : 8'((r * 4 + c) % 11);
    start = 1'b1;
    repeat (3) begin
      tick;
      chk("rst_dout0", dout0, 32'd0);
      chk("rst_dout2", dout2, 32'd0);
      chk("rst_flags", 32'({done0, busy0, done1, busy1, done2, busy2}), 32'd0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick;
    chk("idle_after_rst", 32'({busy0, busy1, busy2}), 32'd0);

    go(RAMP, RAMP);
    chk("busy_e0", 32'({busy0, busy1, busy2}), 32'h7);
    repeat (15) tick;
    chk("busy_e15", 32'(busy0), 32'd1);
    tick;
    chk("busy_e16", 32'(busy0), 32'd0);
    drain;
    repeat (3) tick;
    chk("hold_dout0", dout0, RAMP);

    for (int i = 0; i < 16; i++) d4[i*8+:8] = 8'hFD;
    go(32'hFDFDFDFD, 32'h00000000);
    drain;
    set_ramp;
    d4[0+:8] = 8'h80;
    d4[8+:8] = 8'hFF;
    d4[32+:8] = 8'hFE;
    d4[40+:8] = 8'h81;
    go(32'hFF070d0f, 32'h00070d0f);
    drain;

    set_ramp;
    go(RAMP, RAMP);
    repeat (4) tick;
    for (int i = 0; i < 16; i++) d4[i*8+:8] = 8'(15 - i);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("busy_ignore_start", 32'(busy0), 32'd1);
    for (int i = 0; i < 30 && !done0; i++) tick;
    chk("done_seen", 32'(done0), 32'd1);
    go(REV, REV);
    drain;

    set_ramp;
    go(RAMP, RAMP);
    repeat (7) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    q0.delete();
    q1.delete();
    q2.delete();
    chk("midrst_dout0", dout0, 32'd0);
    chk("midrst_dout2", dout2, 32'd0);
    chk("midrst_busy", 32'({busy0, busy1, busy2}), 32'd0);
    repeat (20) tick;
    chk("midrst_idle", 32'({busy0, done0}), 32'd0);
    go(RAMP, RAMP);
    drain;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
